// File: rtl/piano_pkg.sv
// Shared payload layout and RAM geometry for the note writers, the write arbiter and the song RAM.
package piano_pkg;

  localparam int unsigned PAYLOAD_W = 23;
  localparam int unsigned RAM_AW    = 7;
  localparam int unsigned RAM_DW    = 16;

  localparam int unsigned ADDR_MSB = 22;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned HOLD_BIT = 15;
  localparam int unsigned NOTE_MSB = 14;
  localparam int unsigned NOTE_LSB = 9;
  localparam int unsigned DUR_MSB  = 8;
  localparam int unsigned DUR_LSB  = 0;

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic              hold;
    logic [5:0]        note;
    logic [8:0]        dur;
  } payload_t;

  function automatic logic dur_is_zero(payload_t p);
    return p.dur == '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches requests starting at the pointer, moves past the winner on advance.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [IdxW-1:0]    o_gnt_idx,
  output logic               o_valid
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_ptr_d;
  int unsigned     w_j;

  always_comb begin
    o_valid   = 1'b0;
    o_gnt_idx = '0;
    o_gnt_oh  = '0;
    w_j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!o_valid && i_req[w_j[IdxW-1:0]]) begin
        o_valid   = 1'b1;
        o_gnt_idx = w_j[IdxW-1:0];
      end
    end
    if (o_valid) o_gnt_oh[o_gnt_idx] = 1'b1;
  end

  assign w_ptr_d = (o_gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : o_gnt_idx + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= w_ptr_d;
    end
  end

endmodule

// File: rtl/note_ram_arbiter.sv
// Captures writer release payloads, arbitrates them round-robin into a small FIFO and
// drains the FIFO onto the song RAM write port whenever the RAM is ready.
module note_ram_arbiter
  import piano_pkg::*;
#(
  parameter int unsigned NUM_WRITERS = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          DROP_ZERO   = 1'b1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_WRITERS-1:0]           i_rel_pulse,
  input  logic [PAYLOAD_W*NUM_WRITERS-1:0] i_payload_bus,
  input  logic                             i_ram_ready,
  output logic                             o_ram_we,
  output logic [RAM_AW-1:0]                o_ram_addr,
  output logic [RAM_DW-1:0]                o_ram_wdata,
  output logic [$clog2(FIFO_DEPTH):0]      o_fifo_count,
  output logic                             o_overflow,
  input  logic                             i_clear_overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = (NUM_WRITERS > 1) ? $clog2(NUM_WRITERS) : 1;

  payload_t               r_holding [NUM_WRITERS];
  logic [NUM_WRITERS-1:0] r_pending;
  payload_t               r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]        r_wptr;
  logic [PtrW-1:0]        r_rptr;
  logic [CntW-1:0]        r_count;
  logic                   r_overflow;

  payload_t               w_pl [NUM_WRITERS];
  logic [NUM_WRITERS-1:0] w_accept;
  logic [NUM_WRITERS-1:0] w_pending_d;
  logic                   w_ovf_set;
  logic [NUM_WRITERS-1:0] w_gnt_oh;
  logic [IdxW-1:0]        w_gnt_idx;
  logic                   w_any_req;
  logic                   w_grant;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  payload_t               w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CntW'(FIFO_DEPTH));
  assign w_pop   = o_ram_we;
  // A full FIFO still accepts a grant when the head leaves in the same cycle.
  assign w_grant = w_any_req && (!w_full || w_pop);

  rr_arbiter #(
    .NUM_REQ (NUM_WRITERS),
    .IdxW    (IdxW)
  ) u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (r_pending),
    .i_advance (w_grant),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_valid   (w_any_req)
  );

  always_comb begin
    w_pending_d = r_pending;
    w_ovf_set   = 1'b0;
    for (int i = 0; i < NUM_WRITERS; i++) begin
      w_pl[i]     = payload_t'(i_payload_bus[PAYLOAD_W*i +: PAYLOAD_W]);
      w_accept[i] = i_rel_pulse[i] && !(DROP_ZERO && dur_is_zero(w_pl[i]));
      if (w_grant && w_gnt_oh[i]) w_pending_d[i] = 1'b0;
      if (w_accept[i]) begin
        w_pending_d[i] = 1'b1;
        if (r_pending[i] && !(w_grant && w_gnt_oh[i])) w_ovf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      for (int i = 0; i < NUM_WRITERS; i++) r_holding[i] <= '0;
    end else begin
      r_pending <= w_pending_d;
      for (int i = 0; i < NUM_WRITERS; i++) begin
        if (w_accept[i]) r_holding[i] <= w_pl[i];
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge i_clk) begin
    if (w_grant) r_mem[r_wptr] <= r_holding[w_gnt_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_grant) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      unique case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign o_ram_we     = !w_empty && i_ram_ready;
  assign o_ram_addr   = w_empty ? '0 : w_head.addr;
  assign o_ram_wdata  = w_empty ? '0 : {w_head.hold, w_head.note, w_head.dur};
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;

endmodule

// File: doc/note_ram_arbiter.md
# note_ram_arbiter

Collects finished-note payloads from the bank of note and hold writers and serialises them onto the single write port of the song RAM. Each writer raises a one-cycle release pulse with a stable 23-bit `{addr, write_hold, note, duration}` payload. This block captures it, arbitrates round-robin among simultaneous releases, buffers through a small FIFO, and issues one RAM write per cycle when the RAM grants access. It sits directly downstream of the writers and upstream of the song RAM.

## Interface
- `NUM_WRITERS`, 8: number of writer channels (2..16)
- `FIFO_DEPTH`, 4: write-buffer entries, power of two ≥ 2
- `DROP_ZERO`, 1: 1 = discard payloads whose duration is 0
- `clk`  in  1  sole clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `rel_pulse`  in  NUM_WRITERS  per-writer one-cycle release pulse (writer's falling-edge pulse)
- `payload_bus`  in  23*NUM_WRITERS  writer i occupies bits [23*i+22:23*i]
- `ram_ready`  in  1  RAM accepts a write this cycle (playback reads have priority)
- `ram_we`  out  1  write strobe
- `ram_addr`  out  7  payload[22:16] of head entry
- `ram_wdata`  out  16  payload[15:0] of head entry
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  occupied entries
- `overflow`  out  1  sticky: a payload was lost
- `clear_overflow`  in  1  synchronous clear of `overflow`

## Operation
- Capture: per writer, a pending bit plus 23-bit holding register. `rel_pulse[i]` loads holding[i] and sets pending[i], unless DROP_ZERO=1 and payload[8:0]==0, in which case it is ignored.
- `rel_pulse[i]` while pending[i] is still set and not granted this cycle: holding[i] overwritten with the new payload, `overflow` set. Old payload lost.
- `rel_pulse[i]` in the same cycle pending[i] is granted: the grant takes the old holding value, and the new payload is captured with pending[i] remaining set. No overflow.
- Arbitration: round-robin over pending bits, starting at `rr_ptr`. At most one grant per cycle. A grant occurs only if the FIFO is not full, or a pop occurs in the same cycle. After a grant to index g, `rr_ptr` = (g+1) mod NUM_WRITERS. With no grant, `rr_ptr` holds.
- FIFO: granted holding register pushed. Pop when `ram_we`. Simultaneous push and pop when full is legal, and the count is unchanged.
- Write port: `ram_we` = FIFO non-empty AND `ram_ready`, combinational. `ram_addr` and `ram_wdata` are driven from the FIFO head at all times and are 0 when the FIFO is empty.
- Pending entries are never dropped because the FIFO is full. They wait.
- `overflow` set has priority over `clear_overflow` in the same cycle.
- No address checking: duplicate addresses are written in FIFO order, and the last write wins.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `fifo_count`=0, `overflow`=0. Pending bits, `rr_ptr` and FIFO pointers are all 0.
- Reset asserted mid-operation discards all pending and buffered payloads immediately, with no partial write. `ram_we` drops asynchronously.
- Latency from an uncontended pulse in cycle 0 with empty FIFO and `ram_ready`=1:
  - pending visible in cycle 1;
  - entry at FIFO head in cycle 2;
  - `ram_we`=1 in cycle 2.
- Throughput is 1 write per cycle with `ram_ready` held high. K simultaneous releases drain in K consecutive grant cycles.
- `ram_ready` low stalls pops only. Grants continue until the FIFO is full.

## Structure
- Shared package `piano_pkg` holds:
  - payload field positions: ADDR 22:16, HOLD 15, NOTE 14:9, DUR 8:0;
  - `PAYLOAD_W`=23, `RAM_AW`=7, `RAM_DW`=16.
  - These constants are shared with the writers and the RAM.
- Sub-module `rr_arbiter` (NUM_WRITERS requests in; one-hot grant and grant index out; pointer update on `advance`).
- FIFO is inline: pointers plus a count register.

## Test plan
- Single release: writer 3 pulses payload {addr 0x12, hold 0, note 0x05, dur 7}, FIFO empty, ready=1 -> `ram_we` in cycle 2 with addr 0x12 and wdata 0x0A07. `fifo_count` returns to 0.
- Simultaneous: writers 0, 2 and 5 pulse together with `rr_ptr`=0 -> writes in order 0, 2, 5 in cycles 2, 3, 4. `rr_ptr`=6 afterward.
- Stall: `ram_ready`=0, then 6 releases on distinct writers (FIFO_DEPTH=4) -> `fifo_count` reaches 4, and 2 payloads remain pending. Raising ready -> all 6 written, none lost, `overflow`=0.
- Collision: writer 1 pulses twice, 2 cycles apart, while FIFO is full and ready=0 -> `overflow`=1. Only the second payload is written after ready rises.
- Zero duration: DROP_ZERO=1, payload dur=0 -> no write, `fifo_count` stays 0. Same with DROP_ZERO=0 -> one write with wdata[8:0]=0.
- Reset mid-drain: 3 entries buffered, `reset` low for 1 cycle -> `ram_we` 0 at once, `fifo_count`=0, no writes follow.
